sha256_pad_scheduler: RTL and testbench

//  Front-end controller for the SHA-256 core. Accepts a message as 32-bit big-endian words from the Message Packer.

---
 rtl/sha256_pad_scheduler_if.sv | 25 ++
 rtl/sha256_pad_scheduler.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sha256_pad_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pad_scheduler_if.sv
// Message word stream into the SHA-256 pad/scheduler.
//   s_valid  : word valid (master -> slave)
//   s_ready  : scheduler can accept a word this cycle (slave -> master)
//   s_data   : message word, first byte in [31:24]
//   s_last   : final word of the message
//   s_bytes  : valid bytes in the s_last word, MSB-aligned; 0 means 4
interface sha256_pad_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic [1:0]            s_bytes;

  modport master (
    output s_valid, s_data, s_last, s_bytes,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last, s_bytes,
    output s_ready
  );
endinterface

// File: rtl/sha256_pad_scheduler.sv
// SHA-256 front-end: applies FIPS 180-4 padding to a stream of big-endian
// 32-bit message words, splits the result into 512-bit blocks and issues each
// block to the compression core as 16 back-to-back words.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   s           : message word stream (slave modport of sha256_pad_scheduler_if)
//   core_ready  : core idle, can take a new block
//   core_dv     : block word valid, core_idx = W0..W15, core_word = word
//   core_first  : high while the first block of a message is issued (load IV)
//   core_done   : one-cycle pulse when the core finishes a block
//   msg_done    : one-cycle pulse after the final block's core_done
//   busy        : scheduler not idle
//
// Optional build macro SHA_PAD_SCHED_ABORT_EN adds:
//   abort       : cancel the current message (ignored while idle)
//   core_abort  : one-cycle pulse acknowledging a cancel
module sha256_pad_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sha256_pad_scheduler_if.slave s,
  input  logic                  core_ready,
  output logic                  core_dv,
  output logic [DATA_WIDTH-1:0] core_word,
  output logic [3:0]            core_idx,
  output logic                  core_first,
  input  logic                  core_done,
  output logic                  msg_done,
  output logic                  busy
`ifdef SHA_PAD_SCHED_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  core_abort
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            wr_idx_q, wr_idx_d;      // reaches 16 when the buffer is full
  logic [LEN_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                  first_q, first_d;
  logic                  pad80_q, pad80_d;        // 0x80000000 word still owed
  logic                  len_pend_q, len_pend_d;  // length words still owed
  logic                  zfill_q, zfill_d;        // 0x80 landed at W14/W15: no room for length here
  logic                  last_seen_q, last_seen_d;
  logic                  s_ready_q, s_ready_d;
  logic                  core_dv_q, core_dv_d;
  logic [DATA_WIDTH-1:0] core_word_q, core_word_d;
  logic [3:0]            core_idx_q, core_idx_d;
  logic                  core_first_q, core_first_d;
  logic                  msg_done_q, msg_done_d;
  logic                  busy_q, busy_d;
`ifdef SHA_PAD_SCHED_ABORT_EN
  logic                  core_abort_q, core_abort_d;
`endif

  // Block buffer: every word of a block is rewritten before the block is
  // issued, so it needs no reset.
  logic [DATA_WIDTH-1:0] blk_q [16];
  logic                  blk_we;
  logic [3:0]            blk_wa;
  logic [DATA_WIDTH-1:0] blk_wd;

  logic                  xfer;
  logic [2:0]            nbytes;
  logic [63:0]           bitlen;

  // Keep the valid leading bytes, put 0x80 right after them, zero the rest.
  function automatic logic [DATA_WIDTH-1:0] pad_partial(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] b);
    case (b)
      2'd1:    return {d[31:24], 8'h80, 16'h0000};
      2'd2:    return {d[31:16], 8'h80, 8'h00};
      default: return {d[31:8], 8'h80};
    endcase
  endfunction

  assign xfer   = s.s_valid && s_ready_q;
  assign nbytes = (s.s_last && (s.s_bytes != 2'd0)) ? {1'b0, s.s_bytes} : 3'd4;
  assign bitlen = 64'({byte_cnt_q, 3'b000});

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    byte_cnt_d   = byte_cnt_q;
    first_d      = first_q;
    pad80_d      = pad80_q;
    len_pend_d   = len_pend_q;
    zfill_d      = zfill_q;
    last_seen_d  = last_seen_q;
    core_dv_d    = 1'b0;
    core_word_d  = '0;
    core_idx_d   = 4'd0;
    core_first_d = 1'b0;
    msg_done_d   = 1'b0;
`ifdef SHA_PAD_SCHED_ABORT_EN
    core_abort_d = 1'b0;
`endif
    blk_we       = 1'b0;
    blk_wa       = wr_idx_q[3:0];
    blk_wd       = '0;

    case (state_q)
      IDLE, LOAD: begin
        if (xfer) begin
          blk_we     = 1'b1;
          wr_idx_d   = wr_idx_q + 5'd1;
          byte_cnt_d = byte_cnt_q + LEN_W'(nbytes);
          if (s.s_last) begin
            last_seen_d = 1'b1;
            len_pend_d  = 1'b1;
            state_d     = PAD;
            if (s.s_bytes == 2'd0) begin
              blk_wd  = s.s_data;
              pad80_d = 1'b1;
            end else begin
              blk_wd  = pad_partial(s.s_data, s.s_bytes);
              zfill_d = (wr_idx_q >= 5'd14);
            end
          end else begin
            blk_wd  = s.s_data;
            state_d = (wr_idx_q == 5'd15) ? ISSUE : LOAD;
          end
        end
      end

      PAD: begin
        if (wr_idx_q == 5'd16) begin
          state_d = ISSUE;
        end else begin
          blk_we   = 1'b1;
          wr_idx_d = wr_idx_q + 5'd1;
          if (pad80_q) begin
            blk_wd  = 32'h8000_0000;
            pad80_d = 1'b0;
            zfill_d = (wr_idx_q >= 5'd14);
          end else if (len_pend_q && !zfill_q && (wr_idx_q == 5'd14)) begin
            blk_wd = bitlen[63:32];
          end else if (len_pend_q && !zfill_q && (wr_idx_q == 5'd15)) begin
            blk_wd     = bitlen[31:0];
            len_pend_d = 1'b0;
          end else begin
            blk_wd = '0;
          end
        end
      end

      // core_dv_q doubles as "issue in progress"; core_idx_q is the word counter.
      ISSUE: begin
        if (!core_dv_q) begin
          if (core_ready) begin
            core_dv_d    = 1'b1;
            core_word_d  = blk_q[0];
            core_idx_d   = 4'd0;
            core_first_d = first_q;
          end
        end else if (core_idx_q == 4'd15) begin
          first_d = 1'b0;
          state_d = WAIT;
        end else begin
          core_dv_d    = 1'b1;
          core_word_d  = blk_q[core_idx_q + 4'd1];
          core_idx_d   = core_idx_q + 4'd1;
          core_first_d = first_q;
        end
      end

      WAIT: begin
        if (core_done) begin
          wr_idx_d = 5'd0;
          zfill_d  = 1'b0;
          if (pad80_q || len_pend_q) begin
            state_d = PAD;
          end else if (last_seen_q) begin
            state_d    = DONE;
            msg_done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        byte_cnt_d  = '0;
        first_d     = 1'b1;
        last_seen_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef SHA_PAD_SCHED_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      wr_idx_d     = 5'd0;
      byte_cnt_d   = '0;
      first_d      = 1'b1;
      pad80_d      = 1'b0;
      len_pend_d   = 1'b0;
      zfill_d      = 1'b0;
      last_seen_d  = 1'b0;
      core_dv_d    = 1'b0;
      core_word_d  = '0;
      core_idx_d   = 4'd0;
      core_first_d = 1'b0;
      msg_done_d   = 1'b0;
      blk_we       = 1'b0;
      core_abort_d = 1'b1;
    end
`endif

    s_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_idx_q     <= 5'd0;
      byte_cnt_q   <= '0;
      first_q      <= 1'b1;
      pad80_q      <= 1'b0;
      len_pend_q   <= 1'b0;
      zfill_q      <= 1'b0;
      last_seen_q  <= 1'b0;
      s_ready_q    <= 1'b0;
      core_dv_q    <= 1'b0;
      core_word_q  <= '0;
      core_idx_q   <= 4'd0;
      core_first_q <= 1'b0;
      msg_done_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SHA_PAD_SCHED_ABORT_EN
      core_abort_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      first_q      <= first_d;
      pad80_q      <= pad80_d;
      len_pend_q   <= len_pend_d;
      zfill_q      <= zfill_d;
      last_seen_q  <= last_seen_d;
      s_ready_q    <= s_ready_d;
      core_dv_q    <= core_dv_d;
      core_word_q  <= core_word_d;
      core_idx_q   <= core_idx_d;
      core_first_q <= core_first_d;
      msg_done_q   <= msg_done_d;
      busy_q       <= busy_d;
`ifdef SHA_PAD_SCHED_ABORT_EN
      core_abort_q <= core_abort_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (blk_we) blk_q[blk_wa] <= blk_wd;
  end

  assign s.s_ready  = s_ready_q;
  assign core_dv    = core_dv_q;
  assign core_word  = core_word_q;
  assign core_idx   = core_idx_q;
  assign core_first = core_first_q;
  assign msg_done   = msg_done_q;
  assign busy       = busy_q;
`ifdef SHA_PAD_SCHED_ABORT_EN
  assign core_abort = core_abort_q;
`endif

endmodule

// File: tb/tb_sha256_pad_scheduler.sv
module tb_sha256_pad_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_ready;
  logic        core_dv;
  logic [31:0] core_word;
  logic [3:0]  core_idx;
  logic        core_first;
  logic        core_done;
  logic        msg_done;
  logic        busy;
`ifdef SHA_PAD_SCHED_ABORT_EN
  logic        abort;
  logic        core_abort;
`endif

  sha256_pad_scheduler_if sif ();

  sha256_pad_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .s          (sif),
    .core_ready (core_ready),
    .core_dv    (core_dv),
    .core_word  (core_word),
    .core_idx   (core_idx),
    .core_first (core_first),
    .core_done  (core_done),
    .msg_done   (msg_done),
    .busy       (busy)
`ifdef SHA_PAD_SCHED_ABORT_EN
    ,
    .abort      (abort),
    .core_abort (core_abort)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: expected block words of the message in flight, in issue order.
  logic [31:0] exp_w [$];
  logic        exp_f [$];
  logic [7:0]  msg_q [$];

  int  word_cnt      = 0;
  int  done_wait     = 0;
  bit  block_final   = 1'b0;
  bit  msg_done_exp  = 1'b0;
  int  msg_count     = 0;
  int  hold_ready    = 0;
  bit  expect_dv_next = 1'b0;
  bit  suppress_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Padding computed at byte level: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_expected();
    logic [7:0]  p [$];
    logic [63:0] bl;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    for (int i = 0; i < p.size(); i += 4) begin
      exp_w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
      exp_f.push_back(i < 64);
    end
  endtask

  task automatic fill_random(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic send_msg(input bit garbage);
    int n;
    int nw;
    int guard;
    n  = msg_q.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      int nb;
      nb = (w == nw - 1) ? (n - 4*w) : 4;
      for (int b = 0; b < 4; b++) begin
        if (b < nb) d[31-8*b -: 8] = msg_q[4*w+b];
        else        d[31-8*b -: 8] = garbage ? 8'($urandom) : 8'h00;
      end
      while ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_data  = $urandom;
        sif.s_last  = 1'($urandom);
      end
      guard = 0;
      do begin
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = (w == nw - 1);
        sif.s_bytes = (w == nw - 1) ? 2'(nb % 4) : 2'($urandom);
        guard++;
      end while (!sif.s_ready && guard < 3000);
      if (guard >= 3000) begin
        chk("s_ready_timeout", {63'd0, sif.s_ready}, 64'd1);
        break;
      end
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic wait_msg(input string name);
    int start;
    int guard;
    start = msg_count;
    guard = 0;
    while (msg_count == start && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk({name, "_msg_done_count"}, 64'(msg_count - start), 64'd1);
    chk({name, "_blocks_drained"}, 64'(exp_w.size()), 64'd0);
    exp_w.delete();
    exp_f.delete();
  endtask

  task automatic flush_model();
    exp_w.delete();
    exp_f.delete();
    word_cnt     = 0;
    done_wait    = 0;
    block_final  = 1'b0;
    msg_done_exp = 1'b0;
  endtask

  // Core model and output checker, one process so drive/sample never race.
  initial begin : core_model
    core_ready = 1'b0;
    core_done  = 1'b0;
    forever begin
      @(negedge clk);
      chk("msg_done", {63'd0, msg_done}, {63'd0, msg_done_exp});
      if (msg_done) msg_count++;
      if (expect_dv_next) begin
        chk("issue_start_dv", {63'd0, core_dv}, 64'd1);
        expect_dv_next = 1'b0;
      end

      core_done    = 1'b0;
      msg_done_exp = 1'b0;
      if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0) begin
          core_done    = 1'b1;
          msg_done_exp = block_final;
        end
      end else if (core_dv && $urandom_range(0, 7) == 0) begin
        core_done = 1'b1;   // pulse while issuing must be ignored
      end

      if (core_dv) begin
        if (exp_w.size() == 0) begin
          chk("core_dv_extra", {63'd0, core_dv}, 64'd0);
        end else begin
          chk("core_word",  {32'd0, core_word}, {32'd0, exp_w.pop_front()});
          chk("core_first", {63'd0, core_first}, {63'd0, exp_f.pop_front()});
          chk("core_idx",   {60'd0, core_idx}, 64'(word_cnt));
        end
        chk("s_ready_in_issue", {63'd0, sif.s_ready}, 64'd0);
        word_cnt++;
        if (word_cnt == 16) begin
          word_cnt    = 0;
          block_final = (exp_w.size() == 0);
          done_wait   = suppress_done ? 0 : $urandom_range(1, 6);
        end
      end

      if (hold_ready > 0) begin
        chk("dv_held_off", {63'd0, core_dv}, 64'd0);
        hold_ready--;
        if (hold_ready == 0) begin
          chk("s_ready_blocked", {63'd0, sif.s_ready}, 64'd0);
          core_ready     = 1'b1;
          expect_dv_next = 1'b1;
        end else begin
          core_ready = 1'b0;
        end
      end else begin
        core_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : main
    int guard;
    rst         = 1'b1;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    sif.s_bytes = 2'd0;
`ifdef SHA_PAD_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_s_ready",    {63'd0, sif.s_ready}, 64'd0);
    chk("rst_core_dv",    {63'd0, core_dv}, 64'd0);
    chk("rst_core_word",  {32'd0, core_word}, 64'd0);
    chk("rst_core_idx",   {60'd0, core_idx}, 64'd0);
    chk("rst_core_first", {63'd0, core_first}, 64'd0);
    chk("rst_msg_done",   {63'd0, msg_done}, 64'd0);
    chk("rst_busy",       {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", {63'd0, sif.s_ready}, 64'd1);
    chk("idle_busy",    {63'd0, busy}, 64'd0);

    // "abc" with core_ready held low for the first 60 cycles
    msg_q = {8'h61, 8'h62, 8'h63};
    build_expected();
    chk("model_abc_w0",  {32'd0, exp_w[0]}, 64'h6162_6380);
    chk("model_abc_w15", {32'd0, exp_w[15]}, 64'h0000_0018);
    hold_ready = 60;
    send_msg(1'b0);
    wait_msg("abc");

    // 14 full words: 0x80 at W14, length in a second block
    fill_random(56);
    build_expected();
    chk("model_56_w14", {32'd0, exp_w[14]}, 64'h8000_0000);
    chk("model_56_w15", {32'd0, exp_w[15]}, 64'h0);
    chk("model_56_w31", {32'd0, exp_w[31]}, 64'h0000_01C0);
    send_msg(1'b1);
    wait_msg("len56");

    // 16 full words: data block then pad block
    fill_random(64);
    build_expected();
    chk("model_64_w16", {32'd0, exp_w[16]}, 64'h8000_0000);
    chk("model_64_w31", {32'd0, exp_w[31]}, 64'h0000_0200);
    send_msg(1'b1);
    wait_msg("len64");

    // random lengths, including 0x80 landing at W14/W15 boundaries
    for (int m = 0; m < 12; m++) begin
      int len;
      case (m)
        0: len = 55;
        1: len = 57;
        2: len = 61;
        3: len = 63;
        default: len = $urandom_range(1, 140);
      endcase
      fill_random(len);
      build_expected();
      send_msg(1'b1);
      wait_msg("random");
    end

    // reset in the middle of issuing a block
    msg_q = {8'h61, 8'h62, 8'h63};
    build_expected();
    send_msg(1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(core_dv && core_idx == 4'd7) && guard < 2000);
    chk("reached_idx7", {60'd0, core_idx}, 64'd7);
    #2;
    rst = 1'b1;
    flush_model();
    #1;
    chk("midrst_core_dv",  {63'd0, core_dv}, 64'd0);
    chk("midrst_busy",     {63'd0, busy}, 64'd0);
    chk("midrst_msg_done", {63'd0, msg_done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    msg_q = {8'h61, 8'h62, 8'h63};
    build_expected();
    send_msg(1'b0);
    wait_msg("abc_after_rst");

`ifdef SHA_PAD_SCHED_ABORT_EN
    // abort while waiting for core_done
    suppress_done = 1'b1;
    fill_random(20);
    build_expected();
    send_msg(1'b1);
    guard = 0;
    while ((exp_w.size() != 0 || word_cnt != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    chk("core_abort_pulse", {63'd0, core_abort}, 64'd1);
    chk("abort_busy",       {63'd0, busy}, 64'd0);
    abort = 1'b0;
    flush_model();
    suppress_done = 1'b0;
    @(negedge clk);
    chk("core_abort_single", {63'd0, core_abort}, 64'd0);
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_ignored", {63'd0, core_abort}, 64'd0);
    abort = 1'b0;
    fill_random(30);
    build_expected();
    send_msg(1'b1);
    wait_msg("after_abort");
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
